prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 clk  input  1  single clock, all state on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 load_req  input  1  asynchronous pin level (ui_in[7]); high = enter program-load mode.
REQ-004 nib_strb  input  1  asynchronous pin (ui_in[6]); rising edge = one nibble valid.
REQ-005 nib_data  input  4  nibble value (uio_in[3:0]); stable >=3 clk before and after nib_strb rise.
REQ-006 rd_addr  input  4  fetch address from core PC.
REQ-007 rd_data  output  8  instruction at rd_addr, combinational, no added latency.
REQ-008 core_run  output  1  high = core may advance PC/acc/dmem; low = core holds.
REQ-009 core_rst  output  1  one-cycle pulse that restarts the core (PC=0, acc=0, dmem cleared).
REQ-010 loading  output  1  high while FSM in LOAD_HI or LOAD_LO.
REQ-011 load_addr  output  4  next imem slot to be written.

Function
REQ-012 Storage: 16 x 8-bit instruction array; the only write path is the loader FSM.
REQ-013 load_req and nib_strb each pass through a 2-flop synchronizer before any use.
REQ-014 Strobe edge: third flop; strb_edge = sync2 & ~sync3, so it is high exactly one cycle per rising pin edge.
REQ-015 nib_data is sampled in the strb_edge cycle, without synchronization; the stability rule in REQ-005 covers it.
REQ-016 FSM states: IDLE, LOAD_HI, LOAD_LO, DONE.
REQ-017 IDLE -> LOAD_HI when synced load_req = 1; load_addr <= 0.
REQ-018 LOAD_HI: on strb_edge, hi_nib <= nib_data, then -> LOAD_LO.
REQ-019 LOAD_LO: on strb_edge, mem[load_addr] <= {hi_nib, nib_data}.
REQ-020 LOAD_LO write, load_addr != 15: load_addr += 1, -> LOAD_HI.
REQ-021 LOAD_LO write, load_addr == 15: -> DONE; load_addr wraps to 0.
REQ-022 Strobe edges in IDLE or DONE are ignored; no write occurs.
REQ-023 Abort: synced load_req = 0 in LOAD_HI or LOAD_LO -> IDLE; written slots are kept; a pending hi_nib is discarded.
REQ-024 Abort and strb_edge in the same cycle: abort wins; no write.
REQ-025 DONE -> IDLE when synced load_req = 0; DONE ignores load_req while it stays high.
REQ-026 core_run = 1 in IDLE and DONE; core_run = 0 in LOAD_HI and LOAD_LO.
REQ-027 core_rst pulses high for exactly one cycle on entry to LOAD_HI from IDLE.
REQ-028 core_rst pulses high for exactly one cycle on every exit from LOAD_HI/LOAD_LO (to DONE or IDLE).
REQ-029 loading = 1 exactly in LOAD_HI or LOAD_LO.
REQ-030 A write to mem[a] is visible on rd_data the cycle after the write edge.
REQ-031 Each full byte takes at least 2 strobe edges; there is no upper bound on strobe spacing (no timeout).

Reset
REQ-032 While rst = 1: FSM = IDLE, load_addr = 0, hi_nib = 0, all synchronizer flops = 0.
REQ-033 Reset outputs: core_run = 1, core_rst = 0, loading = 0.
REQ-034 Reset contents: every mem entry = 8'h0B (NOOP).
REQ-035 rst asserted mid-load: immediate return to the REQ-032/033/034 state; partially loaded content is lost.
REQ-036 After rst deasserts, a synced load_req = 1 starts a load normally.

Verification
REQ-037 Reset: pulse rst; read rd_addr 0..15 -> every rd_data = 8'h0B; core_run = 1, core_rst = 0, loading = 0.
REQ-038 Full load: load_req = 1, then 32 nibble strobes carrying 5,9,0,F,1,9,... (16 bytes) -> mem = {59,0F,19,...}; state DONE; core_rst pulses once at entry and once at exit; core_run = 0 throughout; load_addr = 0 at end.
REQ-039 Abort: load 3 bytes (A1,B2,C3) plus one extra high nibble, then drop load_req -> mem[0..2] = A1,B2,C3; mem[3] = 0B; state IDLE; core_run = 1.
REQ-040 Ignored strobes: 4 strobes in IDLE, then 4 in DONE -> no mem change; load_addr unchanged.
REQ-041 Glitch-free edge: hold nib_strb high for 10 cycles -> exactly one strb_edge; exactly one nibble consumed.
REQ-042 Reset mid-load: assert rst after 5 written bytes -> all entries 0B; state IDLE immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/prog_loader_if.sv
// Loader pin/bus bundle: nibble-serial program input, instruction fetch port and core control.
interface prog_loader_if;
  logic       load_req;
  logic       nib_strb;
  logic [3:0] nib_data;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       core_run;
  logic       core_rst;
  logic       loading;
  logic [3:0] load_addr;

  modport master (
    output load_req, nib_strb, nib_data, rd_addr,
    input  rd_data, core_run, core_rst, loading, load_addr
  );

  modport slave (
    input  load_req, nib_strb, nib_data, rd_addr,
    output rd_data, core_run, core_rst, loading, load_addr
  );
endinterface

// File: rtl/prog_loader.sv
// 16x8 instruction store loaded nibble-by-nibble from asynchronous pins; holds and
// restarts the core around each load session.
module prog_loader (
  input logic         clk,
  input logic         rst,
  prog_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD_HI, LOAD_LO, DONE} state_t;

  state_t     state;
  logic       load_p0, load_p1;
  logic       strb_p0, strb_p1, strb_p2;
  logic       load_s;
  logic       strb_edge;
  logic       mem_we;
  logic [3:0] hi_nib;
  logic [3:0] load_addr;
  logic       core_run_r;
  logic       core_rst_r;
  logic       loading_r;
  logic [7:0] mem [16];

  // Synchronizer stages; the third strobe flop only exists to detect the rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_p0 <= 1'b0;
      load_p1 <= 1'b0;
      strb_p0 <= 1'b0;
      strb_p1 <= 1'b0;
      strb_p2 <= 1'b0;
    end else begin
      load_p0 <= bus.load_req;
      load_p1 <= load_p0;
      strb_p0 <= bus.nib_strb;
      strb_p1 <= strb_p0;
      strb_p2 <= strb_p1;
    end
  end

  assign load_s    = load_p1;
  assign strb_edge = strb_p1 & ~strb_p2;

  // An abort (load_s low) in the same cycle as a strobe edge suppresses the write
  assign mem_we = (state == LOAD_LO) && load_s && strb_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h0B;
    end else if (mem_we) begin
      mem[load_addr] <= {hi_nib, bus.nib_data};
    end
  end

  // Loader FSM; core_run/core_rst/loading are registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      load_addr  <= 4'd0;
      hi_nib     <= 4'd0;
      core_run_r <= 1'b1;
      core_rst_r <= 1'b0;
      loading_r  <= 1'b0;
    end else begin
      core_rst_r <= 1'b0;
      case (state)
        IDLE: begin
          if (load_s) begin
            state      <= LOAD_HI;
            load_addr  <= 4'd0;
            core_rst_r <= 1'b1;
            core_run_r <= 1'b0;
            loading_r  <= 1'b1;
          end
        end
        LOAD_HI: begin
          if (!load_s) begin
            state      <= IDLE;
            hi_nib     <= 4'd0;
            core_rst_r <= 1'b1;
            core_run_r <= 1'b1;
            loading_r  <= 1'b0;
          end else if (strb_edge) begin
            hi_nib <= bus.nib_data;
            state  <= LOAD_LO;
          end
        end
        LOAD_LO: begin
          if (!load_s) begin
            state      <= IDLE;
            hi_nib     <= 4'd0;
            core_rst_r <= 1'b1;
            core_run_r <= 1'b1;
            loading_r  <= 1'b0;
          end else if (strb_edge) begin
            if (load_addr == 4'd15) begin
              state      <= DONE;
              load_addr  <= 4'd0;
              core_rst_r <= 1'b1;
              core_run_r <= 1'b1;
              loading_r  <= 1'b0;
            end else begin
              load_addr <= load_addr + 4'd1;
              state     <= LOAD_HI;
            end
          end
        end
        DONE: begin
          if (!load_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_data   = mem[bus.rd_addr];
  assign bus.core_run  = core_run_r;
  assign bus.core_rst  = core_rst_r;
  assign bus.loading   = loading_r;
  assign bus.load_addr = load_addr;

endmodule
